// File: rtl/rtlmeter_pkg.sv
// Shared types for the RTLMeter cycle sampler: snapshot record layout, FSM states
// and a saturating increment used by all counters.
package rtlmeter_pkg;

    localparam int SMP_CNT_W = 64;
    localparam int SMP_EVT_W = 32;
    localparam int SAT_MAX_W = 64;

    typedef struct packed {
        logic                 fin;
        logic [SMP_EVT_W-1:0] events;
        logic [SMP_CNT_W-1:0] cycles;
    } sample_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Increment v by inc, holding at all-ones of a w-bit counter (w <= SAT_MAX_W).
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] v,
                                                     input logic                 inc,
                                                     input int unsigned          w);
        logic [SAT_MAX_W-1:0] top;
        top = (w >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << w) - SAT_MAX_W'(1));
        return (inc && (v != top)) ? v + SAT_MAX_W'(1) : v;
    endfunction

endpackage

// File: rtl/rtlmeter_sample_fifo.sv
// Pointer FIFO with wrap bit; 1-cycle push-to-visible, head read combinationally (0 when empty).
// Push while full is ignored unless a pop happens on the same edge.
module rtlmeter_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_q, rd_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + (AW+1)'(1);
            if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    // When full with a same-edge pop, the write lands in the slot being vacated.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
    end

    assign pop_data = empty ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/rtlmeter_cycle_sampler.sv
// Counts enabled cycles/events and queues periodic {cycles, events} snapshots; with a budget, flushes a final record then halts.
// Record visible 1 cycle after its push; periodic records dropped (and counted) when full, final record waits for space.
module rtlmeter_cycle_sampler
    import rtlmeter_pkg::*;
#(
    parameter int              CNT_W    = 64,
    parameter int              EVT_W    = 32,
    parameter int              INTERVAL = 1000,
    parameter int              DEPTH    = 4,
    parameter longint unsigned LIMIT    = 0,
    parameter int              DROP_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              evt_inc,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic [CNT_W-1:0]  smp_cycles,
    output logic [EVT_W-1:0]  smp_events,
    output logic              smp_final,
    output logic [DROP_W-1:0] drop_cnt,
    output logic [CNT_W-1:0]  cycles,
    output logic              done
);

    localparam int              IVL_W    = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [IVL_W-1:0] IVL_LAST = IVL_W'(INTERVAL - 1);
    localparam logic [CNT_W-1:0] LIMIT_C  = CNT_W'(LIMIT);
    // A budget beyond the counter range can never be hit because the counter saturates.
    localparam bit LIMIT_ON = (LIMIT != 0) && ((CNT_W >= 64) || (LIMIT < (64'd1 << CNT_W)));

    typedef struct packed {
        logic             fin;
        logic [EVT_W-1:0] events;
        logic [CNT_W-1:0] cycles;
    } rec_t;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [EVT_W-1:0]  evt_q, evt_d;
    logic [IVL_W-1:0]  ivl_q, ivl_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              done_q, done_d;

    logic fifo_full, fifo_empty, pop, space, push;
    rec_t push_rec, pop_rec;

    assign pop   = !fifo_empty && smp_ready;
    assign space = !fifo_full || pop;

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        evt_d    = evt_q;
        ivl_d    = ivl_q;
        drop_d   = drop_q;
        done_d   = done_q;
        push     = 1'b0;
        push_rec = '0;
        case (state_q)
            RUN: begin
                if (en) begin
                    cyc_d = CNT_W'(sat_inc(SAT_MAX_W'(cyc_q), 1'b1, CNT_W));
                    evt_d = EVT_W'(sat_inc(SAT_MAX_W'(evt_q), evt_inc, EVT_W));
                    ivl_d = (ivl_q == IVL_LAST) ? '0 : ivl_q + IVL_W'(1);
                    if (LIMIT_ON && (cyc_d == LIMIT_C)) begin
                        state_d = FLUSH;
                    end else if (ivl_q == IVL_LAST) begin
                        if (space) begin
                            push            = 1'b1;
                            push_rec.fin    = 1'b0;
                            push_rec.events = evt_d;
                            push_rec.cycles = cyc_d;
                        end else begin
                            drop_d = DROP_W'(sat_inc(SAT_MAX_W'(drop_q), 1'b1, DROP_W));
                        end
                    end
                end
            end
            FLUSH: begin
                if (space) begin
                    push            = 1'b1;
                    push_rec.fin    = 1'b1;
                    push_rec.events = evt_q;
                    push_rec.cycles = cyc_q;
                    state_d         = DONE;
                    done_d          = 1'b1;
                end
            end
            DONE:    ;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            cyc_q   <= '0;
            evt_q   <= '0;
            ivl_q   <= '0;
            drop_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            evt_q   <= evt_d;
            ivl_q   <= ivl_d;
            drop_q  <= drop_d;
            done_q  <= done_d;
        end
    end

    rtlmeter_sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(rec_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_rec),
        .full      (fifo_full),
        .pop       (pop),
        .pop_data  (pop_rec),
        .empty     (fifo_empty)
    );

    assign smp_valid  = !fifo_empty;
    assign smp_cycles = pop_rec.cycles;
    assign smp_events = pop_rec.events;
    assign smp_final  = pop_rec.fin;
    assign drop_cnt   = drop_q;
    assign cycles     = cyc_q;
    assign done       = done_q;

endmodule

// File: tb/tb_rtlmeter_cycle_sampler.sv
// Bench for rtlmeter_cycle_sampler: a budgeted (LIMIT=10) and an unbudgeted instance,
// INTERVAL=4, DEPTH=2, both checked each cycle against a queue-based reference model.
module tb_rtlmeter_cycle_sampler;
    import rtlmeter_pkg::*;

    logic clk, rst, en, evt_inc, rdy;

    logic        a_valid, a_final, a_done, b_valid, b_final, b_done;
    logic [63:0] a_cycles, a_live, b_cycles, b_live;
    logic [31:0] a_events, b_events;
    logic [15:0] a_drop, b_drop;

    rtlmeter_cycle_sampler #(.CNT_W(64), .EVT_W(32), .INTERVAL(4), .DEPTH(2), .LIMIT(10), .DROP_W(16)) dut_a (
        .clk(clk), .rst(rst), .en(en), .evt_inc(evt_inc),
        .smp_valid(a_valid), .smp_ready(rdy), .smp_cycles(a_cycles), .smp_events(a_events),
        .smp_final(a_final), .drop_cnt(a_drop), .cycles(a_live), .done(a_done));

    rtlmeter_cycle_sampler #(.CNT_W(64), .EVT_W(32), .INTERVAL(4), .DEPTH(2), .LIMIT(0), .DROP_W(16)) dut_b (
        .clk(clk), .rst(rst), .en(en), .evt_inc(evt_inc),
        .smp_valid(b_valid), .smp_ready(rdy), .smp_cycles(b_cycles), .smp_events(b_events),
        .smp_final(b_final), .drop_cnt(b_drop), .cycles(b_live), .done(b_done));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: counts enabled edges, queues records, budget flag per instance.
    longint  lim   [2] = '{10, 0};
    longint  mk    [2];
    longint  me    [2];
    longint  mn    [2];
    longint  mdrop [2];
    bit      mflush[2];
    bit      mdone [2];
    sample_t mq    [2][$];

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mk[i] = 0; me[i] = 0; mn[i] = 0; mdrop[i] = 0;
                mflush[i] = 0; mdone[i] = 0;
                mq[i].delete();
            end else begin
                bit      pop_m, space_m;
                sample_t s;
                pop_m   = (mq[i].size() > 0) && rdy;
                space_m = (mq[i].size() < 2) || pop_m;
                if (pop_m) void'(mq[i].pop_front());
                if (!mflush[i] && !mdone[i]) begin
                    if (en) begin
                        mk[i]++; mn[i]++;
                        if (evt_inc) me[i]++;
                        if (lim[i] != 0 && mk[i] == lim[i]) begin
                            mflush[i] = 1;
                        end else if (mn[i] % 4 == 0) begin
                            if (space_m) begin
                                s.fin = 1'b0; s.events = 32'(me[i]); s.cycles = 64'(mk[i]);
                                mq[i].push_back(s);
                            end else begin
                                mdrop[i]++;
                            end
                        end
                    end
                end else if (mflush[i] && space_m) begin
                    s.fin = 1'b1; s.events = 32'(me[i]); s.cycles = 64'(mk[i]);
                    mq[i].push_back(s);
                    mflush[i] = 0;
                    mdone[i]  = 1;
                end
            end
        end
    end

    function automatic sample_t mhead(input int i);
        if (mq[i].size() > 0) return mq[i][0];
        return '0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_model();
        sample_t h;
        h = mhead(0);
        chk("a_valid",  a_valid,  mq[0].size() != 0);
        chk("a_cycles", a_cycles, h.cycles);
        chk("a_events", a_events, h.events);
        chk("a_final",  a_final,  h.fin);
        chk("a_drop",   a_drop,   mdrop[0]);
        chk("a_live",   a_live,   mk[0]);
        chk("a_done",   a_done,   mdone[0]);
        h = mhead(1);
        chk("b_valid",  b_valid,  mq[1].size() != 0);
        chk("b_cycles", b_cycles, h.cycles);
        chk("b_events", b_events, h.events);
        chk("b_final",  b_final,  h.fin);
        chk("b_drop",   b_drop,   mdrop[1]);
        chk("b_live",   b_live,   mk[1]);
        chk("b_done",   b_done,   mdone[1]);
    endtask

    sample_t got_a[$];
    sample_t got_b[$];

    // Records the heads that the upcoming edge will pop, then advances one cycle.
    task automatic tick();
        sample_t s;
        if (a_valid && rdy) begin
            s.fin = a_final; s.events = a_events; s.cycles = a_cycles;
            got_a.push_back(s);
        end
        if (b_valid && rdy) begin
            s.fin = b_final; s.events = b_events; s.cycles = b_cycles;
            got_b.push_back(s);
        end
        @(posedge clk);
        @(negedge clk);
        cmp_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        got_a.delete();
        got_b.delete();
    endtask

    task automatic chk_rec(input string tag, input sample_t r, input longint c, input longint e, input bit f);
        chk({tag, "_cyc"}, r.cycles, c);
        chk({tag, "_evt"}, r.events, e);
        chk({tag, "_fin"}, r.fin, f);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; evt_inc = 1'b0; rdy = 1'b0;
        @(negedge clk);
        tick();
        chk("rst_valid", a_valid, 0);
        chk("rst_cycles", a_live, 0);
        chk("rst_data", a_cycles, 0);

        // Free run to the budget
        rst = 1'b0; en = 1'b1; evt_inc = 1'b1; rdy = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 10) chk("fr_done_e10", a_done, 0);
            if (c == 11) chk("fr_done_e11", a_done, 1);
        end
        chk("fr_nrec", got_a.size(), 3);
        if (got_a.size() == 3) begin
            chk_rec("fr_r0", got_a[0], 4, 4, 0);
            chk_rec("fr_r1", got_a[1], 8, 8, 0);
            chk_rec("fr_r2", got_a[2], 10, 10, 1);
        end
        chk("fr_hold", a_live, 10);
        chk("fr_b_nrec", got_b.size(), 3);

        // Overflow (unbudgeted) and blocked final (budgeted)
        do_reset();
        en = 1'b1; evt_inc = 1'b1; rdy = 1'b0;
        for (int c = 0; c < 16; c++) tick();
        chk("ov_drop", b_drop, 2);
        chk("ov_head", b_cycles, 4);
        chk("bf_done", a_done, 0);
        chk("bf_drop", a_drop, 0);
        en = 1'b0; rdy = 1'b1;
        tick();
        chk("bf_done_after_pop", a_done, 1);
        for (int c = 0; c < 3; c++) tick();
        chk("ov_nrec", got_b.size(), 2);
        if (got_b.size() == 2) begin
            chk_rec("ov_r0", got_b[0], 4, 4, 0);
            chk_rec("ov_r1", got_b[1], 8, 8, 0);
        end
        chk("bf_nrec", got_a.size(), 3);
        if (got_a.size() == 3) chk_rec("bf_final", got_a[2], 10, 10, 1);

        // Gated counting
        do_reset();
        rdy = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            en = (c % 2 == 0);
            evt_inc = (c % 4 == 2);
            tick();
            if (c == 7) chk("gt_valid_c7", b_valid, 0);
        end
        chk("gt_valid_c8", b_valid, 1);
        chk("gt_cyc", b_cycles, 4);
        chk("gt_evt", b_events, 2);
        chk("gt_fin", b_final, 0);
        chk("gt_live", a_live, 4);

        // Full FIFO with a pop on the third sample's edge
        do_reset();
        en = 1'b1; evt_inc = 1'b0; rdy = 1'b0;
        for (int c = 0; c < 11; c++) tick();
        rdy = 1'b1;
        tick();
        rdy = 1'b0; en = 1'b0;
        chk("fp_drop", b_drop, 0);
        chk("fp_head", b_cycles, 8);
        tick();
        rdy = 1'b1;
        tick();
        tick();
        chk("fp_empty", b_valid, 0);
        chk("fp_nrec", got_b.size(), 3);
        if (got_b.size() == 3) chk("fp_r2", got_b[2].cycles, 12);

        // Asynchronous reset between edges
        do_reset();
        en = 1'b1; evt_inc = 1'b1; rdy = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        chk("ar_pre_valid", a_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_cycles", a_live, 0);
        chk("ar_valid", a_valid, 0);
        chk("ar_drop", b_drop, 0);
        chk("ar_b_valid", b_valid, 0);
        rst = 1'b0;
        got_a.delete();
        got_b.delete();
        for (int c = 0; c < 4; c++) tick();
        chk("ar_first_cyc", a_cycles, 4);
        chk("ar_first_fin", a_final, 0);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            en      = ($urandom_range(0, 3) != 0);
            evt_inc = $urandom_range(0, 1) == 1;
            rdy     = ($urandom_range(0, 2) != 0);
            rst     = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
